// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: controller state encoding and register-index
// width. Also used by the stage registers and the forwarding unit.
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pipe_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_hazard_det.sv
// Load-use comparator: flags when the instruction in IF_ID reads the
// destination of a load still sitting in ID_EX. x0 never creates a hazard.
module pipe_hazard_det
    import pipe_pkg::*;
(
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    output logic             stall_o
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare each live source operand against the pending load destination
    always_comb begin
        rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
        rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);
        stall_o = ex_is_load_i && (ex_rd_i != ZERO_REG) && (rs1_hit || rs2_hit);
    end

endmodule : pipe_hazard_det

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller. Drives active-low latch enables
// and flush bits of the PC/IF_ID/ID_EX/EX_MEM/MEM_WB registers, resolving
// data-memory freezes, load-use stalls, mispredict squashes and halt drain.
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating event counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
`ifdef PIPE_CTRL_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             dmem_busy_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_mispredict_i,
    input  logic             ex_halt_i,
    output logic             latchn_pc_o,
    output logic             latchn_if_id_o,
    output logic             latchn_id_ex_o,
    output logic             latchn_ex_mem_o,
    output logic             latchn_mem_wb_o,
    output logic             flush_if_id_o,
    output logic             flush_id_ex_o,
    output logic             redirect_o,
    output logic             halt_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_o,
    output logic [CNT_W-1:0] perf_flush_o,
    output logic [CNT_W-1:0] perf_freeze_o
`endif
);

    localparam int CNT_BITS = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] DRAIN_LOAD = CNT_BITS'(DRAIN_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

    pipe_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                halt_q, halt_d;

    logic load_use;
    logic lat_pc, lat_if_id, lat_id_ex, lat_ex_mem, lat_mem_wb;
    logic fl_if_id, fl_id_ex, redir;

    pipe_hazard_det u_hazard (
        .ex_is_load_i (ex_is_load_i),
        .ex_rd_i      (ex_rd_i),
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_use_rs1_i (id_use_rs1_i),
        .id_use_rs2_i (id_use_rs2_i),
        .stall_o      (load_use)
    );

    // Prioritised control decode and next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_pc     = 1'b0;
        lat_if_id  = 1'b0;
        lat_id_ex  = 1'b0;
        lat_ex_mem = 1'b0;
        lat_mem_wb = 1'b0;
        fl_if_id   = 1'b0;
        fl_id_ex   = 1'b0;
        redir      = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (dmem_busy_i) begin
                    // Whole-pipe freeze; hazards re-evaluate once memory returns
                    {lat_pc, lat_if_id, lat_id_ex, lat_ex_mem, lat_mem_wb} = 5'b11111;
                end else if (ex_halt_i) begin
                    // Stop fetching, let everything older than the halt retire
                    lat_pc    = 1'b1;
                    lat_if_id = 1'b1;
                    fl_id_ex  = 1'b1;
                    state_d   = ST_DRAIN;
                    cnt_d     = DRAIN_LOAD;
                end else if (ex_mispredict_i) begin
                    redir    = 1'b1;
                    fl_if_id = 1'b1;
                    fl_id_ex = 1'b1;
                end else if (load_use) begin
                    // One bubble suffices: the load moves on next cycle
                    lat_pc    = 1'b1;
                    lat_if_id = 1'b1;
                    fl_id_ex  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (dmem_busy_i) begin
                    {lat_pc, lat_if_id, lat_id_ex, lat_ex_mem, lat_mem_wb} = 5'b11111;
                end else begin
                    lat_pc    = 1'b1;
                    lat_if_id = 1'b1;
                    fl_id_ex  = 1'b1;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                {lat_pc, lat_if_id, lat_id_ex, lat_ex_mem, lat_mem_wb} = 5'b11111;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halt_d = (state_d == ST_HALTED);
    end

    // While reset is held, every stage register is frozen and flushed
    always_comb begin
        latchn_pc_o     = !RSTn || lat_pc;
        latchn_if_id_o  = !RSTn || lat_if_id;
        latchn_id_ex_o  = !RSTn || lat_id_ex;
        latchn_ex_mem_o = !RSTn || lat_ex_mem;
        latchn_mem_wb_o = !RSTn || lat_mem_wb;
        flush_if_id_o   = !RSTn || fl_if_id;
        flush_id_ex_o   = !RSTn || fl_id_ex;
        redirect_o      = RSTn && redir;
        halt_o          = halt_q;
    end

    // State, drain counter and registered halt flag
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Event counters; HALTED never counts so the totals are stable afterwards
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
            if (dmem_busy_i) begin
                freeze_cnt_d = sat_inc(freeze_cnt_q);
            end
        end
        if ((state_q == ST_RUN) && !dmem_busy_i && !ex_halt_i) begin
            if (ex_mispredict_i) begin
                flush_cnt_d = sat_inc(flush_cnt_q);
            end else if (load_use) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign perf_stall_o  = stall_cnt_q;
    assign perf_flush_o  = flush_cnt_q;
    assign perf_freeze_o = freeze_cnt_q;
`endif

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Output vector layout compared by check_eq:
// {latchn pc,if_id,id_ex,ex_mem,mem_wb, flush if_id,id_ex, redirect, halt}.
module tb_pipe_ctrl;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       dmem_busy_i = 1'b0;
    logic [4:0] id_rs1_i = '0;
    logic [4:0] id_rs2_i = '0;
    logic       id_use_rs1_i = 1'b0;
    logic       id_use_rs2_i = 1'b0;
    logic       ex_is_load_i = 1'b0;
    logic [4:0] ex_rd_i = '0;
    logic       ex_mispredict_i = 1'b0;
    logic       ex_halt_i = 1'b0;
    logic       latchn_pc_o, latchn_if_id_o, latchn_id_ex_o, latchn_ex_mem_o, latchn_mem_wb_o;
    logic       flush_if_id_o, flush_id_ex_o, redirect_o, halt_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_o, perf_flush_o, perf_freeze_o;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [8:0] V_RESET  = 9'b11111_11_0_0;
    localparam logic [8:0] V_IDLE   = 9'b00000_00_0_0;
    localparam logic [8:0] V_FREEZE = 9'b11111_00_0_0;
    localparam logic [8:0] V_BUBBLE = 9'b11000_01_0_0;
    localparam logic [8:0] V_SQUASH = 9'b00000_11_1_0;
    localparam logic [8:0] V_HALTED = 9'b11111_00_0_1;

    pipe_ctrl #(
        .DRAIN_CYCLES (3)
    ) dut (
        .CLK             (CLK),
        .RSTn            (RSTn),
        .dmem_busy_i     (dmem_busy_i),
        .id_rs1_i        (id_rs1_i),
        .id_rs2_i        (id_rs2_i),
        .id_use_rs1_i    (id_use_rs1_i),
        .id_use_rs2_i    (id_use_rs2_i),
        .ex_is_load_i    (ex_is_load_i),
        .ex_rd_i         (ex_rd_i),
        .ex_mispredict_i (ex_mispredict_i),
        .ex_halt_i       (ex_halt_i),
        .latchn_pc_o     (latchn_pc_o),
        .latchn_if_id_o  (latchn_if_id_o),
        .latchn_id_ex_o  (latchn_id_ex_o),
        .latchn_ex_mem_o (latchn_ex_mem_o),
        .latchn_mem_wb_o (latchn_mem_wb_o),
        .flush_if_id_o   (flush_if_id_o),
        .flush_id_ex_o   (flush_id_ex_o),
        .redirect_o      (redirect_o),
        .halt_o          (halt_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_o    (perf_stall_o),
        .perf_flush_o    (perf_flush_o),
        .perf_freeze_o   (perf_freeze_o)
`endif
    );

    always #5 CLK = ~CLK;

    // Halt and mispredict together in EX is an illegal program situation
    always @(posedge CLK) begin
        if (RSTn) begin
            assert (!(ex_halt_i && ex_mispredict_i))
                else $error("illegal: ex_halt_i and ex_mispredict_i together");
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outv();
        return {23'd0, latchn_pc_o, latchn_if_id_o, latchn_id_ex_o, latchn_ex_mem_o,
                latchn_mem_wb_o, flush_if_id_o, flush_id_ex_o, redirect_o, halt_o};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_loaduse(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
        ex_is_load_i = 1'b1;
        ex_rd_i      = rd;
        id_rs1_i     = rs1;
        id_use_rs1_i = u1;
        id_rs2_i     = rs2;
        id_use_rs2_i = u2;
    endtask

    task automatic clear_inputs();
        dmem_busy_i     = 1'b0;
        ex_is_load_i    = 1'b0;
        ex_rd_i         = '0;
        id_rs1_i        = '0;
        id_rs2_i        = '0;
        id_use_rs1_i    = 1'b0;
        id_use_rs2_i    = 1'b0;
        ex_mispredict_i = 1'b0;
        ex_halt_i       = 1'b0;
    endtask

    initial begin
        // Reset held
        #1;
        check_eq("reset_vec", outv(), {23'd0, V_RESET});
        tick();
        tick();
        check_eq("reset_held", outv(), {23'd0, V_RESET});

        // Release away from the edge, first edge is idle run
        @(negedge CLK);
        RSTn = 1'b1;
        tick();
        check_eq("run_idle", outv(), {23'd0, V_IDLE});

        // Load-use via rs2 -> one bubble, then load gone
        set_loaduse(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
        #1;
        check_eq("lu_rs2", outv(), {23'd0, V_BUBBLE});
        tick();
        ex_is_load_i = 1'b0;
        #1;
        check_eq("lu_after", outv(), {23'd0, V_IDLE});

        // Same stimulus but rd = x0 -> no stall
        set_loaduse(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        #1;
        check_eq("lu_x0", outv(), {23'd0, V_IDLE});

        // rs1 path matching, then rs1 match but not used
        set_loaduse(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        #1;
        check_eq("lu_rs1", outv(), {23'd0, V_BUBBLE});
        tick();
        set_loaduse(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        #1;
        check_eq("lu_rs1_unused", outv(), {23'd0, V_IDLE});
        clear_inputs();
        tick();

        // Mispredict beats load-use
        set_loaduse(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        ex_mispredict_i = 1'b1;
        #1;
        check_eq("mispredict", outv(), {23'd0, V_SQUASH});
        tick();
        clear_inputs();
        #1;
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_flush", perf_flush_o, 32'd1);
        check_eq("perf_stall", perf_stall_o, 32'd2);
`endif

        // Five-cycle memory freeze with load-use pending, then the bubble
        set_loaduse(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        dmem_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq($sformatf("freeze_%0d", i), outv(), {23'd0, V_FREEZE});
            tick();
        end
        dmem_busy_i = 1'b0;
        #1;
        check_eq("freeze_then_bubble", outv(), {23'd0, V_BUBBLE});
        tick();
        clear_inputs();
        #1;
        check_eq("freeze_done", outv(), {23'd0, V_IDLE});
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_freeze5", perf_freeze_o, 32'd5);
        check_eq("perf_stall3", perf_stall_o, 32'd3);
`endif

        // Halt: 3 drain cycles plus one frozen cycle before halt_o
        ex_halt_i = 1'b1;
        #1;
        check_eq("halt_run", outv(), {23'd0, V_BUBBLE});
        tick();
        ex_halt_i = 1'b0;
        ex_mispredict_i = 1'b1;
        #1;
        check_eq("drain1_ignmisp", outv(), {23'd0, V_BUBBLE});
        tick();
        ex_mispredict_i = 1'b0;
        dmem_busy_i = 1'b1;
        #1;
        check_eq("drain_busy", outv(), {23'd0, V_FREEZE});
        tick();
        dmem_busy_i = 1'b0;
        #1;
        check_eq("drain2", outv(), {23'd0, V_BUBBLE});
        tick();
        #1;
        check_eq("drain3", outv(), {23'd0, V_BUBBLE});
        tick();
        check_eq("halted", outv(), {23'd0, V_HALTED});

        // HALTED ignores everything
        set_loaduse(5'd2, 5'd2, 1'b1, 5'd0, 1'b0);
        dmem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        check_eq("halted_stay", outv(), {23'd0, V_HALTED});
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_freeze_halted", perf_freeze_o, 32'd6);
`endif
        clear_inputs();

        // Reset from HALTED, halt again, reset asynchronously mid-drain
        @(negedge CLK);
        RSTn = 1'b0;
        #1;
        check_eq("rst_from_halted", outv(), {23'd0, V_RESET});
        @(negedge CLK);
        RSTn = 1'b1;
        tick();
        ex_halt_i = 1'b1;
        tick();
        ex_halt_i = 1'b0;
        tick();
        #2;
        RSTn = 1'b0;
        #1;
        check_eq("rst_mid_drain", outv(), {23'd0, V_RESET});
`ifdef PIPE_CTRL_PERF_EN
        check_eq("perf_clear", perf_freeze_o, 32'd0);
`endif
        @(negedge CLK);
        RSTn = 1'b1;
        tick();
        check_eq("run_after_rst", outv(), {23'd0, V_IDLE});
        set_loaduse(5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
        #1;
        check_eq("stall_after_rst", outv(), {23'd0, V_BUBBLE});
        tick();
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_ctrl

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. It drives the active-low latch enables and flush/bubble controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It resolves data-memory freezes, load-use stalls, branch mispredict squashes and halt draining. One instance sits at core top level, beside the stage registers.

Parameters:
DRAIN_CYCLES, 3, cycles EX_MEM/MEM_WB keep latching after halt confirmation so older instructions retire
CNT_W, 32, width of performance counters (only with optional feature)

Ports:
CLK  in  1  core clock
RSTn  in  1  asynchronous active-low reset
dmem_busy_i  in  1  MEM stage waiting on data memory; freeze whole pipe
id_rs1_i  in  5  rs1 of instruction in IF_ID
id_rs2_i  in  5  rs2 of instruction in IF_ID
id_use_rs1_i  in  1  IF_ID instruction reads rs1
id_use_rs2_i  in  1  IF_ID instruction reads rs2
ex_is_load_i  in  1  ID_EX holds valid (unflushed) load
ex_rd_i  in  5  rd of ID_EX instruction
ex_mispredict_i  in  1  EX resolved branch/jump, outcome != bpr
ex_halt_i  in  1  EX confirms halt instruction (valid, unflushed)
latchn_pc_o  out  1  0 = PC updates
latchn_if_id_o  out  1  0 = IF_ID latches
latchn_id_ex_o  out  1  0 = ID_EX latches
latchn_ex_mem_o  out  1  0 = EX_MEM latches
latchn_mem_wb_o  out  1  0 = MEM_WB latches
flush_if_id_o  out  1  written into IF_ID flush bit (squash)
flush_id_ex_o  out  1  written into ID_EX flush bit (bubble)
redirect_o  out  1  PC selects EX-computed target this cycle
halt_o  out  1  pipeline drained and stopped (registered)

Behaviour:
- State register: RUN, DRAIN, HALTED; drain counter width clog2(DRAIN_CYCLES+1).
- Async reset (RSTn=0): state RUN, counter 0, halt_o 0, perf counters 0. While RSTn=0, all latchn_* = 1, flush_* = 1, redirect_o = 0.
- Control outputs are combinational from state and inputs (zero latency). State, counter and halt_o update on posedge CLK.
- RUN priority, highest first:
  1. dmem_busy_i: all latchn_* = 1, flush_* = 0, redirect 0. No hazard is acted on. Conditions re-evaluate once busy drops.
  2. ex_halt_i: latchn_pc/if_id = 1, latchn_id_ex/ex_mem/mem_wb = 0, flush_id_ex = 1. Next state DRAIN, counter loads DRAIN_CYCLES. An ex_mispredict_i in the same cycle is ignored; a bench assertion flags it as illegal.
  3. ex_mispredict_i: redirect_o = 1, all latchn_* = 0, flush_if_id = 1, flush_id_ex = 1. Squashes two younger instructions. Load-use is ignored this cycle.
  4. load-use: ex_is_load_i & ex_rd_i != 0 & ((id_use_rs1_i & id_rs1_i == ex_rd_i) | (id_use_rs2_i & id_rs2_i == ex_rd_i)). Then latchn_pc/if_id = 1, latchn_id_ex/ex_mem/mem_wb = 0, flush_id_ex = 1. This is exactly a one-cycle bubble, because the load leaves ID_EX next cycle.
  5. else: all latchn_* = 0, flush_* = 0.
- DRAIN:
  - PC and IF_ID frozen. ID_EX latches with flush_id_ex = 1. EX_MEM and MEM_WB latch.
  - dmem_busy_i freezes everything and holds the counter.
  - Otherwise the counter decrements each cycle. At counter==1 the next state is HALTED.
  - Hazard and mispredict inputs are ignored.
- HALTED: all latchn_* = 1, flush_* = 0, redirect_o = 0, halt_o = 1. The only exit is reset.
- Reset asserted mid-DRAIN or mid-stall: immediate return to reset values; no partial state survives.

Optional Feature:
PIPE_CTRL_PERF_EN:
- Defined: adds outputs perf_stall_o[CNT_W], perf_flush_o[CNT_W], perf_freeze_o[CNT_W].
  - perf_stall_o increments on each load-use stall cycle.
  - perf_flush_o increments on each mispredict cycle.
  - perf_freeze_o increments on each dmem_busy_i cycle in RUN or DRAIN.
  - Counters saturate at all-ones, freeze in HALTED and clear on reset.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state enum (RUN/DRAIN/HALTED), REG_W=5 register-index width, ZERO_REG constant. The same package is reused by the stage registers and the forwarding unit.
- One natural sub-module: pipe_hazard_det, the combinational load-use comparator producing a single stall bit.
- All prioritisation and state stay in pipe_ctrl.

Test Plan:
- Reset release, no hazards -> first edge all latchn_*=0, flush_*=0, halt_o=0.
- ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> latchn_pc=latchn_if_id=1, flush_id_ex=1 for exactly 1 cycle. Same stimulus with ex_rd=0 -> no stall.
- ex_mispredict=1 together with an active load-use -> redirect_o=1, flush_if_id=1, flush_id_ex=1, all latchn=0; perf_flush=1, perf_stall=0.
- ex_halt=1, DRAIN_CYCLES=3, dmem_busy=1 during 2nd drain cycle -> halt_o rises after exactly 4 edges (3 drain cycles plus 1 frozen cycle). After that all latchn=1, indefinitely.
- dmem_busy=1 for 5 cycles while load-use condition is present -> all latchn=1 for 5 cycles, then a 1-cycle bubble; perf_freeze=5.
- RSTn pulsed low asynchronously mid-DRAIN -> outputs immediately at reset values; after release, state is RUN and halt_o=0.
